// File: rtl/redmule_mx_fp16_serializer.sv
// Splits wide FP16 beats into NUM_LANES-wide slices for the MX encoder and marks MX block ends.
// Optional sticky Inf/NaN detection is enabled by defining REDMULE_MX_SER_SPECIAL_CHK_EN.
module redmule_mx_fp16_serializer #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned BITW        = 16,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned BLOCK_ELEMS = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      wide_valid_i,
  output logic                      wide_ready_o,
  input  logic [DATA_W-1:0]         wide_data_i,
  output logic                      fp16_valid_o,
  input  logic                      fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] fp16_data_o,
  output logic                      fp16_last_o,
  output logic                      special_o
);

  localparam int unsigned SLICE_W = NUM_LANES * BITW;
  localparam int unsigned SLICES  = DATA_W / SLICE_W;
  localparam int unsigned BSLICES = BLOCK_ELEMS / NUM_LANES;
  localparam int unsigned SCW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned BCW     = (BSLICES > 1) ? $clog2(BSLICES) : 1;

  generate
    if ((DATA_W % SLICE_W) != 0 || (BLOCK_ELEMS % NUM_LANES) != 0 || SLICES == 0 || BSLICES == 0) begin : g_bad_cfg
      $error("redmule_mx_fp16_serializer: DATA_W must be a multiple of NUM_LANES*BITW and BLOCK_ELEMS a multiple of NUM_LANES");
    end
  endgenerate

  typedef enum logic {EMPTY, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [SLICES-1:0][SLICE_W-1:0]  buf_q;
  logic [SCW-1:0]                  slice_cnt_q;
  logic [BCW-1:0]                  blk_cnt_q;
  logic                            last_slice;
  logic                            accept;
  logic                            handshake;

  assign last_slice = (slice_cnt_q == SCW'(SLICES - 1));
  assign accept     = wide_valid_i & wide_ready_o;
  assign handshake  = fp16_valid_o & fp16_ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A reload on the final slice keeps us in DRAIN so consecutive beats stream without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = DRAIN;
      DRAIN: if (handshake && last_slice && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    wide_ready_o = 1'b0;
    fp16_valid_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        EMPTY: wide_ready_o = ~flush_i;
        DRAIN: begin
          fp16_valid_o = 1'b1;
          wide_ready_o = ~flush_i & last_slice & fp16_ready_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      slice_cnt_q <= '0;
      blk_cnt_q   <= '0;
    end else begin
      if (accept) begin
        slice_cnt_q <= '0;
      end else if (handshake) begin
        slice_cnt_q <= last_slice ? '0 : slice_cnt_q + SCW'(1);
      end
      // Block position follows the output stream only, so blocks freely straddle beats.
      if (handshake) begin
        blk_cnt_q <= (blk_cnt_q == BCW'(BSLICES - 1)) ? '0 : blk_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_q <= wide_data_i;
    end
  end

  assign fp16_data_o = buf_q[slice_cnt_q];
  assign fp16_last_o = fp16_valid_o & (blk_cnt_q == BCW'(BSLICES - 1));

`ifdef REDMULE_MX_SER_SPECIAL_CHK_EN
  logic special_q;
  logic special_hit;

  // An all-ones FP16 exponent field marks Inf or NaN.
  always_comb begin
    special_hit = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fp16_data_o[l*BITW+10 +: 5] == 5'h1F) special_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      special_q <= 1'b0;
    end else if (handshake && special_hit) begin
      special_q <= 1'b1;
    end
  end

  assign special_o = special_q & ~rst_i;
`else
  assign special_o = 1'b0;
`endif

endmodule

// File: tb/tb_redmule_mx_fp16_serializer.sv
// Scoreboard bench for redmule_mx_fp16_serializer: a slice-stream model predicts data, block ends and the sticky flag.
// Define REDMULE_MX_SER_SPECIAL_CHK_EN for both bench and RTL to exercise the Inf/NaN detector.
module tb_redmule_mx_fp16_serializer;

  localparam int DATA_W      = 256;
  localparam int BITW        = 16;
  localparam int NUM_LANES   = 4;
  localparam int BLOCK_ELEMS = 32;
  localparam int SLICE_W     = NUM_LANES * BITW;
  localparam int SLICES      = DATA_W / SLICE_W;
  localparam int BSLICES     = BLOCK_ELEMS / NUM_LANES;
  localparam int ELEMS       = DATA_W / BITW;
`ifdef REDMULE_MX_SER_SPECIAL_CHK_EN
  localparam bit SPECIAL_EN = 1'b1;
`else
  localparam bit SPECIAL_EN = 1'b0;
`endif

  logic                 clk_i;
  logic                 rst_i;
  logic                 flush_i;
  logic                 wide_valid_i;
  logic                 wide_ready_o;
  logic [DATA_W-1:0]    wide_data_i;
  logic                 fp16_valid_o;
  logic                 fp16_ready_i;
  logic [SLICE_W-1:0]   fp16_data_o;
  logic                 fp16_last_o;
  logic                 special_o;

  redmule_mx_fp16_serializer #(
    .DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES), .BLOCK_ELEMS(BLOCK_ELEMS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .wide_valid_i(wide_valid_i), .wide_ready_o(wide_ready_o), .wide_data_i(wide_data_i),
    .fp16_valid_o(fp16_valid_o), .fp16_ready_i(fp16_ready_i), .fp16_data_o(fp16_data_o),
    .fp16_last_o(fp16_last_o), .special_o(special_o)
  );

  typedef struct {
    logic [SLICE_W-1:0] data;
    logic               last;
  } exp_t;

  exp_t               exp_q[$];
  int                 hs_cyc[$];
  logic               hs_last[$];
  logic [SLICE_W-1:0] hs_data[$];
  int                 acc_cyc[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  int                 model_pos = 0;
  bit                 model_special = 1'b0;
  bit                 hold_v = 1'b0;
  logic [SLICE_W-1:0] hold_d;
  logic               hold_l;
  int                 ready_mode = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [SLICE_W-1:0] act, input logic [SLICE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hasSpecial(input logic [SLICE_W-1:0] s);
    logic [BITW-1:0] e;
    for (int l = 0; l < NUM_LANES; l++) begin
      e = s[l*BITW +: BITW];
      if (e[14:10] == 5'h1F) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: every accepted beat becomes SLICES slices in element order; block ends fall every BSLICES slices of the stream.
  always @(negedge clk_i) begin
    exp_t               e;
    logic [DATA_W-1:0]  beat;
    checkOutput("special", {63'd0, special_o}, {63'd0, rst_i ? 1'b0 : model_special});
    if (rst_i || flush_i) begin
      if (rst_i) begin
        checkOutput("rst_valid", {63'd0, fp16_valid_o}, 64'd0);
        checkOutput("rst_wready", {63'd0, wide_ready_o}, 64'd0);
        checkOutput("rst_last", {63'd0, fp16_last_o}, 64'd0);
      end else begin
        checkOutput("flush_wready", {63'd0, wide_ready_o}, 64'd0);
      end
      exp_q.delete();
      model_pos     = 0;
      model_special = 1'b0;
      hold_v        = 1'b0;
    end else begin
      if (hold_v) begin
        checkOutput("stall_valid", {63'd0, fp16_valid_o}, 64'd1);
        checkOutput("stall_data", fp16_data_o, hold_d);
        checkOutput("stall_last", {63'd0, fp16_last_o}, {63'd0, hold_l});
      end
      hold_v = fp16_valid_o && !fp16_ready_i;
      hold_d = fp16_data_o;
      hold_l = fp16_last_o;
      if (fp16_valid_o && fp16_ready_i) begin
        hs_cyc.push_back(cyc);
        hs_last.push_back(fp16_last_o);
        hs_data.push_back(fp16_data_o);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_slice: got %0h, expected no output (cycle %0d)", fp16_data_o, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("slice_data", fp16_data_o, e.data);
          checkOutput("slice_last", {63'd0, fp16_last_o}, {63'd0, e.last});
          if (SPECIAL_EN && hasSpecial(e.data)) model_special = 1'b1;
        end
      end
      if (wide_valid_i && wide_ready_o) begin
        acc_cyc.push_back(cyc);
        beat = wide_data_i;
        for (int s = 0; s < SLICES; s++) begin
          e.data = beat[s*SLICE_W +: SLICE_W];
          e.last = ((model_pos % BSLICES) == BSLICES - 1);
          exp_q.push_back(e);
          model_pos++;
        end
      end
    end
  end

  // Ready patterns: 0 = always ready, 1 = repeating 1,0,0, 2 = random with ~75% ready.
  initial begin
    int phase = 0;
    fp16_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        1: begin
          fp16_ready_i = (phase == 0);
          phase = (phase + 1) % 3;
        end
        2: begin
          fp16_ready_i = ($urandom_range(0, 3) != 0);
          phase = 0;
        end
        default: begin
          fp16_ready_i = 1'b1;
          phase = 0;
        end
      endcase
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] beat);
    bit acc = 1'b0;
    int n = 0;
    wide_data_i  = beat;
    wide_valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      acc = wide_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 200);
    checkOutput("beat_accepted", {63'd0, acc}, 64'd1);
    wide_valid_i = 1'b0;
  endtask

  task automatic waitHs(input int n);
    int t = 0;
    while (hs_cyc.size() < n && t < 300) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    checkOutput("hs_reached", {63'd0, hs_cyc.size() >= n}, 64'd1);
  endtask

  task automatic doFlush();
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic clearLogs();
    hs_cyc.delete();
    hs_last.delete();
    hs_data.delete();
    acc_cyc.delete();
  endtask

  function automatic logic [DATA_W-1:0] seqBeat(input logic [15:0] base);
    logic [DATA_W-1:0] b;
    for (int i = 0; i < ELEMS; i++) b[i*BITW +: BITW] = base + 16'(i);
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] finiteBeat();
    logic [DATA_W-1:0] b;
    logic [15:0]       v;
    for (int i = 0; i < ELEMS; i++) begin
      v = 16'($urandom_range(0, 16'h7BFF));
      v[15] = 1'($urandom_range(0, 1));
      b[i*BITW +: BITW] = v;
    end
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] randBeat();
    logic [DATA_W-1:0] b;
    logic [31:0]       w;
    for (int i = 0; i < DATA_W / 32; i++) begin
      w = $urandom();
      b[i*32 +: 32] = w;
    end
    return b;
  endfunction

  initial begin
    logic [DATA_W-1:0] b1;
    logic [DATA_W-1:0] b2;
    int                nlast;
    int                t;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    wide_valid_i = 1'b0;
    wide_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_wready", {63'd0, wide_ready_o}, 64'd1);
    checkOutput("post_rst_valid", {63'd0, fp16_valid_o}, 64'd0);
    checkOutput("post_rst_special", {63'd0, special_o}, 64'd0);
    @(posedge clk_i);
    #1;

    $display("[TB] single beat, ready held high");
    clearLogs();
    applyStimulus(seqBeat(16'h3C00));
    waitHs(4);
    checkOutput("first_latency", 64'(hs_cyc[0] - acc_cyc[0]), 64'd1);
    checkOutput("single_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    checkOutput("first_slice", hs_data[0], 64'h3C03_3C02_3C01_3C00);
    nlast = 0;
    foreach (hs_last[i]) nlast += int'(hs_last[i]);
    checkOutput("single_no_last", 64'(nlast), 64'd0);

    $display("[TB] four back-to-back beats");
    doFlush();
    clearLogs();
    for (int k = 0; k < 4; k++) applyStimulus(finiteBeat());
    waitHs(16);
    checkOutput("b2b_span", 64'(hs_cyc[15] - hs_cyc[0]), 64'd15);
    checkOutput("b2b_last8", {63'd0, hs_last[7]}, 64'd1);
    checkOutput("b2b_last16", {63'd0, hs_last[15]}, 64'd1);
    nlast = 0;
    foreach (hs_last[i]) nlast += int'(hs_last[i]);
    checkOutput("b2b_last_count", 64'(nlast), 64'd2);
    for (int k = 1; k < 4; k++) checkOutput("b2b_accept_gap", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd4);

    $display("[TB] stalled output");
    doFlush();
    ready_mode = 1;
    clearLogs();
    applyStimulus(finiteBeat());
    waitHs(4);
    checkOutput("stall_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'd9);
    ready_mode = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] flush mid-beat");
    clearLogs();
    b1 = finiteBeat();
    b2 = finiteBeat();
    applyStimulus(b1);
    waitHs(2);
    flush_i      = 1'b1;
    wide_valid_i = 1'b1;
    wide_data_i  = b2;
    #1;
    checkOutput("flush_no_accept", {63'd0, wide_ready_o}, 64'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    applyStimulus(b2);
    waitHs(6);
    checkOutput("flush_accepts", 64'(acc_cyc.size()), 64'd2);
    checkOutput("flush_restart", hs_data[2], b2[SLICE_W-1:0]);

    $display("[TB] reset mid-beat");
    clearLogs();
    applyStimulus(finiteBeat());
    waitHs(2);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {63'd0, fp16_valid_o}, 64'd0);
    checkOutput("rst_mid_wready", {63'd0, wide_ready_o}, 64'd1);
    clearLogs();
    applyStimulus(finiteBeat());
    applyStimulus(finiteBeat());
    waitHs(8);
    checkOutput("rst_blk_mid", {63'd0, hs_last[3]}, 64'd0);
    checkOutput("rst_blk_end", {63'd0, hs_last[7]}, 64'd1);

    $display("[TB] Inf element in slice 3");
    doFlush();
    clearLogs();
    b1 = seqBeat(16'h3C00);
    b1[12*BITW +: BITW] = 16'h7C00;
    applyStimulus(b1);
    waitHs(4);
    @(posedge clk_i);
    #1;
    checkOutput("special_set", {63'd0, special_o}, {63'd0, SPECIAL_EN});
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("special_hold", {63'd0, special_o}, {63'd0, SPECIAL_EN});
    doFlush();
    checkOutput("special_flush", {63'd0, special_o}, 64'd0);

    $display("[TB] random traffic");
    ready_mode = 2;
    for (int k = 0; k < 60; k++) begin
      t = $urandom_range(0, 19);
      if (t == 0) begin
        doFlush();
      end else if (t < 4) begin
        repeat ($urandom_range(1, 5)) @(posedge clk_i);
        #1;
      end
      applyStimulus(randBeat());
    end
    ready_mode = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
